match_argmin: RTL and testbench

MATCH_ARGMIN -- requirements
Module: match_argmin

---
 rtl/match_argmin.sv | 175 +++++++++++++++++
 tb/tb_match_argmin.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/match_argmin.sv
// Streaming arg-min over a raster of template-match scores, holding the best offset until acked.
// Optional runner-up tracking and ambiguity flag enabled by defining MATCH_SECOND_BEST_EN.
module match_argmin #(
  parameter int unsigned ROI_DEPTH    = 6,
  parameter int unsigned ROI_WIDTH    = 6,
  parameter int unsigned POI_DEPTH    = 4,
  parameter int unsigned POI_WIDTH    = 4,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned AMBIG_MARGIN = 4,
  localparam int unsigned ROWS = ROI_DEPTH - POI_DEPTH + 1,
  localparam int unsigned COLS = ROI_WIDTH - POI_WIDTH + 1,
  localparam int unsigned RW   = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW   = ($clog2(COLS) > 1) ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  output logic               score_ready,
  output logic               best_valid,
  input  logic               best_ack,
  output logic [RW-1:0]      best_row,
  output logic [CW-1:0]      best_col,
  output logic [SCORE_W-1:0] best_score,
  output logic               busy,
  output logic               status,
  output logic               ambiguous
);

  localparam logic [RW-1:0] LastRow = RW'(ROWS - 1);
  localparam logic [CW-1:0] LastCol = CW'(COLS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StReport} state_e;

  state_e state_q, state_d;

  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      min_row_q, min_row_d;
  logic [CW-1:0]      min_col_q, min_col_d;
  logic [SCORE_W-1:0] min_q, min_d;
  logic               seen_q, seen_d;
  logic               status_q, status_d;

  logic accept;
  logic last_beat;

  // A beat offered together with start is dropped; start always wins.
  assign accept    = (state_q == StCollect) && score_valid && !start;
  assign last_beat = (row_q == LastRow) && (col_q == LastCol);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StCollect;
      end
      StCollect: begin
        if (start)                      state_d = StCollect;
        else if (accept && last_beat)   state_d = StReport;
      end
      StReport: begin
        if (start)         state_d = StCollect;
        else if (best_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    score_ready = (state_q == StCollect);
    busy        = (state_q == StCollect);
    best_valid  = (state_q == StReport);
    status      = status_q;
    best_row    = min_row_q;
    best_col    = min_col_q;
    best_score  = min_q;
  end

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    min_row_d = min_row_q;
    min_col_d = min_col_q;
    min_d     = min_q;
    seen_d    = seen_q;
    status_d  = status_q;
    if (start) begin
      row_d     = '0;
      col_d     = '0;
      min_row_d = '0;
      min_col_d = '0;
      min_d     = '0;
      seen_d    = 1'b0;
      status_d  = 1'b0;
    end else if (accept) begin
      seen_d = 1'b1;
      // Strict less-than keeps the earliest position on ties.
      if (!seen_q || (score < min_q)) begin
        min_d     = score;
        min_row_d = row_q;
        min_col_d = col_q;
      end
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = last_beat ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (last_beat) status_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q     <= '0;
      col_q     <= '0;
      min_row_q <= '0;
      min_col_q <= '0;
      min_q     <= '0;
      seen_q    <= 1'b0;
      status_q  <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      min_row_q <= min_row_d;
      min_col_q <= min_col_d;
      min_q     <= min_d;
      seen_q    <= seen_d;
      status_q  <= status_d;
    end
  end

`ifdef MATCH_SECOND_BEST_EN
  logic [SCORE_W-1:0] second_q, second_d;
  logic [SCORE_W-1:0] gap;

  always_comb begin
    second_d = second_q;
    if (start) begin
      second_d = '1;
    end else if (accept && seen_q) begin
      if (score < min_q)         second_d = min_q;
      else if (score < second_q) second_d = score;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      second_q <= '1;
    end else begin
      second_q <= second_d;
    end
  end

  // Runner-up never drops below the best, so the difference cannot wrap.
  assign gap       = second_q - min_q;
  assign ambiguous = best_valid && (gap < SCORE_W'(AMBIG_MARGIN));
`else
  assign ambiguous = 1'b0;
`endif

endmodule

// File: tb/tb_match_argmin.sv
// Directed bench for match_argmin: a table of full searches plus hand-written
// sequences for abort, mid-search reset and start/ack collision in REPORT.
module tb_match_argmin;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        score_valid;
  logic [15:0] score;
  logic        score_ready;
  logic        best_valid;
  logic        best_ack;
  logic [1:0]  best_row;
  logic [1:0]  best_col;
  logic [15:0] best_score;
  logic        busy;
  logic        status;
  logic        ambiguous;

  int n_total = 0;
  int n_pass  = 0;

  match_argmin dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .score_valid(score_valid),
    .score      (score),
    .score_ready(score_ready),
    .best_valid (best_valid),
    .best_ack   (best_ack),
    .best_row   (best_row),
    .best_col   (best_col),
    .best_score (best_score),
    .busy       (busy),
    .status     (status),
    .ambiguous  (ambiguous)
  );

  always #5 clk = ~clk;

  // Scores are written as a concatenation, so beat i lives at index 8-i.
  typedef struct {
    string            name;
    logic [8:0][15:0] s;
    bit               gaps;
    logic [1:0]       er;
    logic [1:0]       ec;
    logic [15:0]      esc;
    bit               eamb;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit amb_exp(input bit a);
`ifdef MATCH_SECOND_BEST_EN
    return a;
`else
    return 1'b0 & a;
`endif
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v, input bit gaps, input string name);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        score_valid = 1'b0;
        @(negedge clk);
        check({name, " ready_in_gap"}, score_ready, 1);
      end
    end
    score_valid = 1'b1;
    score       = v;
    @(negedge clk);
    score_valid = 1'b0;
  endtask

  // Feeds nine beats after start has already been issued, then checks the report.
  task automatic run_beats(input vec_t v);
    check({v.name, " busy"}, busy, 1);
    check({v.name, " status_clr"}, status, 0);
    for (int i = 0; i < 8; i++) feed(v.s[8-i], v.gaps, v.name);
    check({v.name, " no_early_valid"}, best_valid, 0);
    feed(v.s[0], v.gaps, v.name);
    check({v.name, " best_valid"}, best_valid, 1);
    check({v.name, " row"}, best_row, v.er);
    check({v.name, " col"}, best_col, v.ec);
    check({v.name, " score"}, best_score, v.esc);
    check({v.name, " status"}, status, 1);
    check({v.name, " ready_low"}, score_ready, 0);
    check({v.name, " ambiguous"}, ambiguous, amb_exp(v.eamb));
    @(negedge clk);
    check({v.name, " held_valid"}, best_valid, 1);
    check({v.name, " held_score"}, best_score, v.esc);
    best_ack = 1'b1;
    @(negedge clk);
    best_ack = 1'b0;
    check({v.name, " acked"}, best_valid, 0);
    check({v.name, " status_kept"}, status, 1);
  endtask

  initial begin
    vec_t v;
    reset       = 1'b1;
    start       = 1'b0;
    score_valid = 1'b0;
    score       = '0;
    best_ack    = 1'b0;

    vecs[0] = '{"descend", {16'd50, 16'd40, 16'd30, 16'd20, 16'd10, 16'd60, 16'd70, 16'd80,
                16'd90}, 1'b0, 2'd1, 2'd1, 16'd10, 1'b0};
    vecs[1] = '{"all_five_gaps", {9{16'd5}}, 1'b1, 2'd0, 2'd0, 16'd5, 1'b1};
    vecs[2] = '{"close_pair", {16'd10, 16'd12, {7{16'd99}}}, 1'b0, 2'd0, 2'd0, 16'd10, 1'b1};
    vecs[3] = '{"far_pair", {16'd10, 16'd20, {7{16'd99}}}, 1'b0, 2'd0, 2'd0, 16'd10, 1'b0};
    vecs[4] = '{"last_min", {{8{16'd100}}, 16'd7}, 1'b1, 2'd2, 2'd2, 16'd7, 1'b0};
    vecs[5] = '{"all_ones", {9{16'hFFFF}}, 1'b0, 2'd0, 2'd0, 16'hFFFF, 1'b1};
    vecs[6] = '{"ties", {16'd8, 16'd8, 16'd3, 16'd7, 16'd3, 16'd9, 16'd9, 16'd9, 16'd9},
                1'b1, 2'd0, 2'd2, 16'd3, 1'b1};
    vecs[7] = '{"full_width", {16'd300, 16'd299, 16'hFFFF, 16'hFFFE, 16'd256, 16'd257,
                16'd1000, 16'd2000, 16'd255}, 1'b0, 2'd2, 2'd2, 16'd255, 1'b1};

    repeat (2) @(negedge clk);
    check("rst best_valid", best_valid, 0);
    check("rst ready", score_ready, 0);
    check("rst busy", busy, 0);
    check("rst status", status, 0);
    check("rst best_score", best_score, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle ready", score_ready, 0);

    for (int k = 0; k < 8; k++) begin
      pulse_start();
      run_beats(vecs[k]);
    end

    // Abort: four low beats, then start with a zero beat offered in the same cycle.
    pulse_start();
    for (int i = 0; i < 4; i++) feed(16'd1, 1'b0, "abort_pre");
    start       = 1'b1;
    score_valid = 1'b1;
    score       = 16'd0;
    @(negedge clk);
    start       = 1'b0;
    score_valid = 1'b0;
    v = vecs[4];
    v.name = "abort";
    run_beats(v);

    // Reset in the middle of a search.
    pulse_start();
    for (int i = 0; i < 5; i++) feed(16'd3, 1'b0, "mid_rst_pre");
    reset = 1'b1;
    #1;
    check("mid_rst best_valid", best_valid, 0);
    check("mid_rst ready", score_ready, 0);
    check("mid_rst busy", busy, 0);
    check("mid_rst status", status, 0);
    check("mid_rst row", best_row, 0);
    check("mid_rst col", best_col, 0);
    check("mid_rst score", best_score, 0);
    check("mid_rst ambiguous", ambiguous, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst ready", score_ready, 0);
      check("post_rst busy", busy, 0);
    end
    pulse_start();
    v = vecs[0];
    v.name = "post_rst";
    run_beats(v);

    // start and best_ack together in REPORT: start wins.
    pulse_start();
    for (int i = 0; i < 9; i++) feed(vecs[3].s[8-i], 1'b0, "collide_pre");
    check("collide in_report", best_valid, 1);
    start    = 1'b1;
    best_ack = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    best_ack = 1'b0;
    check("collide best_valid", best_valid, 0);
    check("collide status", status, 0);
    v = vecs[2];
    v.name = "collide";
    run_beats(v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
